signal_to_order: RTL and testbench

Converts the signed trade-signal stream emitted by `tick_pipeline` (`out_valid`/`out_signal`) into order requests on a valid/ready order port, priced at the most recent tick. Tracks the resulting net position and enforces a symmetric position limit and a post-order cooldown. Sits directly downstream of `tick_pipeline` and shares its tick input, so one block feeds it both signals and prices.

---
 rtl/fixed_point_pkg.sv | 23 ++
 rtl/order_cooldown_timer.sv | 26 ++
 rtl/signal_to_order.sv | 109 ++++++++++
 tb/tb_signal_to_order.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fixed_point_pkg.sv
// Shared fixed-point and trading types for the tick pipeline and its order stage.
package fixed_point_pkg;

  typedef logic [31:0] q16_t;

  typedef logic signed [1:0] signal_t;
  localparam signal_t SIG_BUY     = 2'sb01;
  localparam signal_t SIG_SELL    = 2'sb11;
  localparam signal_t SIG_HOLD    = 2'sb00;
  localparam signal_t SIG_ILLEGAL = 2'sb10;

  typedef enum logic {
    SIDE_BUY  = 1'b0,
    SIDE_SELL = 1'b1
  } order_side_t;

  typedef struct packed {
    order_side_t side;
    logic [7:0]  qty;
    q16_t        px;
  } order_t;

endpackage

// File: rtl/order_cooldown_timer.sv
// Down-counter that holds off new orders for COOLDOWN cycles after a fill.
module order_cooldown_timer #(
  parameter int COOLDOWN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic count,
  output logic done
);

  // A zero cooldown never enters COOL, but the counter still needs one bit.
  localparam int W = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
  localparam logic [W-1:0] INIT = W'(COOLDOWN);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        cnt <= '0;
    else if (load)                     cnt <= INIT;
    else if (count && cnt != '0)       cnt <= cnt - W'(1);
  end

  assign done = (cnt == W'(1));

endmodule

// File: rtl/signal_to_order.sv
// Turns tick_pipeline trade signals into limit orders priced at the latest tick,
// with net-position limiting and a post-fill cooldown.
module signal_to_order
  import fixed_point_pkg::*;
#(
  parameter int MAX_POS   = 4,
  parameter int ORDER_QTY = 1,
  parameter int COOLDOWN  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        px_valid,
  input  logic [31:0] px,
  input  logic        sig_valid,
  input  logic [1:0]  sig,
  output logic        ord_valid,
  input  logic        ord_ready,
  output logic        ord_side,
  output logic [7:0]  ord_qty,
  output logic [31:0] ord_px,
  output logic [7:0]  position,
  output logic        busy,
  output logic [15:0] drop_cnt
);

  typedef enum logic [1:0] {IDLE, SEND, COOL} state_t;

  localparam logic signed [8:0] MAX9 = 9'(MAX_POS);
  localparam logic signed [8:0] QTY9 = 9'(ORDER_QTY);

  state_t            state, state_nx;
  q16_t              last_px;
  logic              have_px;
  logic signed [8:0] pos9;
  order_t            ord_q, ord_d;

  signal_t           s;
  logic              is_buy, is_sell, price_ok, at_limit, accept, drop, hs, cool_done;
  logic signed [8:0] headroom, qty_clamp, fill9;

  assign s        = signal_t'(sig);
  assign is_buy   = (s == SIG_BUY);
  assign is_sell  = (s == SIG_SELL);
  // A tick arriving alongside the signal is a usable price via the bypass.
  assign price_ok = have_px | px_valid;
  assign headroom = is_sell ? (MAX9 + pos9) : (MAX9 - pos9);
  assign at_limit = is_sell ? (pos9 <= -MAX9) : (pos9 >= MAX9);
  assign qty_clamp = (headroom < QTY9) ? headroom : QTY9;

  assign accept = (state == IDLE) && sig_valid && (is_buy || is_sell) && price_ok && !at_limit;
  assign drop   = sig_valid && (s != SIG_HOLD) && !accept;
  assign hs     = (state == SEND) && ord_ready;
  assign fill9  = $signed({1'b0, ord_q.qty});

  always_comb begin
    ord_d      = ord_q;
    ord_d.side = is_sell ? SIDE_SELL : SIDE_BUY;
    ord_d.qty  = qty_clamp[7:0];
    ord_d.px   = px_valid ? px : last_px;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = SEND;
      SEND:    if (hs) state_nx = (COOLDOWN == 0) ? IDLE : COOL;
      COOL:    if (cool_done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  order_cooldown_timer #(.COOLDOWN(COOLDOWN)) u_cool (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (hs),
    .count (state == COOL),
    .done  (cool_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last_px   <= '0;
      have_px   <= 1'b0;
      pos9      <= '0;
      ord_q     <= '0;
      ord_valid <= 1'b0;
      busy      <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      state     <= state_nx;
      ord_valid <= (state_nx == SEND);
      busy      <= (state_nx != IDLE);
      if (px_valid) begin
        last_px <= px;
        have_px <= 1'b1;
      end
      if (accept) ord_q <= ord_d;
      if (hs) pos9 <= (ord_q.side == SIDE_SELL) ? pos9 - fill9 : pos9 + fill9;
      if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end

  assign ord_side = ord_q.side;
  assign ord_qty  = ord_q.qty;
  assign ord_px   = ord_q.px;
  assign position = pos9[7:0];

endmodule

// File: tb/tb_signal_to_order.sv
// Directed bench: default instance (qty 1) plus a qty-3 instance for clamping.
module tb_signal_to_order;

  logic        clk, rst_n;
  logic        px_valid, sig_valid, ord_ready;
  logic [31:0] px;
  logic [1:0]  sig;
  logic        ord_valid, ord_side, busy;
  logic [7:0]  ord_qty, position;
  logic [31:0] ord_px;
  logic [15:0] drop_cnt;

  logic        b_px_valid, b_sig_valid, b_ord_ready;
  logic [31:0] b_px;
  logic [1:0]  b_sig;
  logic        b_ord_valid, b_ord_side, b_busy;
  logic [7:0]  b_ord_qty, b_position;
  logic [31:0] b_ord_px;
  logic [15:0] b_drop_cnt;

  int tests = 0;
  int fails = 0;

  signal_to_order #(.MAX_POS(4), .ORDER_QTY(1), .COOLDOWN(8)) dut (
    .clk(clk), .rst_n(rst_n), .px_valid(px_valid), .px(px),
    .sig_valid(sig_valid), .sig(sig), .ord_valid(ord_valid), .ord_ready(ord_ready),
    .ord_side(ord_side), .ord_qty(ord_qty), .ord_px(ord_px),
    .position(position), .busy(busy), .drop_cnt(drop_cnt)
  );

  signal_to_order #(.MAX_POS(4), .ORDER_QTY(3), .COOLDOWN(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .px_valid(b_px_valid), .px(b_px),
    .sig_valid(b_sig_valid), .sig(b_sig), .ord_valid(b_ord_valid), .ord_ready(b_ord_ready),
    .ord_side(b_ord_side), .ord_qty(b_ord_qty), .ord_px(b_ord_px),
    .position(b_position), .busy(b_busy), .drop_cnt(b_drop_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    tests++;
    if ({ord_valid, ord_side, ord_qty, ord_px, position, busy, drop_cnt} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got v=%b s=%b q=%0d px=%h pos=%0d busy=%b drop=%0d, want all 0",
               ord_valid, ord_side, ord_qty, ord_px, position, busy, drop_cnt);
    end
  endtask

  task automatic test_no_price();
    sig_valid = 1'b1; sig = 2'b01;
    step();
    sig_valid = 1'b0;
    tests++;
    if (ord_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL no_price_order: got v=%b busy=%b, want 0 0", ord_valid, busy);
    end
    tests++;
    if (drop_cnt !== 16'd1) begin
      fails++;
      $display("FAIL no_price_drop: got %0d, want 1", drop_cnt);
    end
  endtask

  task automatic test_basic();
    int busy_cycles;
    px_valid = 1'b1; px = 32'h0064_0000;
    step();
    px_valid = 1'b0;
    sig_valid = 1'b1; sig = 2'b01; ord_ready = 1'b1;
    step();
    sig_valid = 1'b0;
    tests++;
    if (ord_valid !== 1'b1 || ord_side !== 1'b0 || ord_qty !== 8'd1 || ord_px !== 32'h0064_0000) begin
      fails++;
      $display("FAIL basic_order: got v=%b s=%b q=%0d px=%h, want 1 0 1 00640000",
               ord_valid, ord_side, ord_qty, ord_px);
    end
    busy_cycles = busy ? 1 : 0;
    step();
    tests++;
    if (ord_valid !== 1'b0 || position !== 8'd1) begin
      fails++;
      $display("FAIL basic_fill: got v=%b pos=%0d, want 0 1", ord_valid, position);
    end
    for (int i = 0; i < 20; i++) begin
      if (busy) busy_cycles++;
      step();
    end
    tests++;
    if (busy_cycles != 9) begin
      fails++;
      $display("FAIL basic_busy_len: got %0d cycles, want 9", busy_cycles);
    end
  endtask

  task automatic test_backpressure();
    ord_ready = 1'b0;
    sig_valid = 1'b1; sig = 2'b11;
    step();
    sig_valid = 1'b0;
    tests++;
    if (ord_valid !== 1'b1 || ord_side !== 1'b1 || ord_qty !== 8'd1 || ord_px !== 32'h0064_0000) begin
      fails++;
      $display("FAIL bp_order: got v=%b s=%b q=%0d px=%h, want 1 1 1 00640000",
               ord_valid, ord_side, ord_qty, ord_px);
    end
    for (int i = 0; i < 5; i++) begin
      sig_valid = (i == 1); sig = 2'b11;
      step();
      tests++;
      if (ord_valid !== 1'b1 || ord_side !== 1'b1 || ord_qty !== 8'd1 ||
          ord_px !== 32'h0064_0000 || position !== 8'd1) begin
        fails++;
        $display("FAIL bp_hold[%0d]: got v=%b s=%b q=%0d px=%h pos=%0d, want 1 1 1 00640000 1",
                 i, ord_valid, ord_side, ord_qty, ord_px, position);
      end
    end
    sig_valid = 1'b0;
    tests++;
    if (drop_cnt !== 16'd2) begin
      fails++;
      $display("FAIL bp_drop: got %0d, want 2", drop_cnt);
    end
    ord_ready = 1'b1;
    step();
    ord_ready = 1'b0;
    tests++;
    if (ord_valid !== 1'b0 || position !== 8'd0) begin
      fails++;
      $display("FAIL bp_fill: got v=%b pos=%0d, want 0 0", ord_valid, position);
    end
    step(12);
    tests++;
    if (position !== 8'd0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL bp_once: got pos=%0d busy=%b, want 0 0", position, busy);
    end
  endtask

  task automatic test_bypass();
    ord_ready = 1'b1;
    px_valid = 1'b1; px = 32'h0065_8000;
    sig_valid = 1'b1; sig = 2'b01;
    step();
    px_valid = 1'b0; sig_valid = 1'b0;
    tests++;
    if (ord_valid !== 1'b1 || ord_px !== 32'h0065_8000) begin
      fails++;
      $display("FAIL bypass_px: got v=%b px=%h, want 1 00658000", ord_valid, ord_px);
    end
    step();
    tests++;
    if (position !== 8'd1) begin
      fails++;
      $display("FAIL bypass_fill: got pos=%0d, want 1", position);
    end
    step(10);
  endtask

  task automatic test_illegal();
    sig_valid = 1'b1; sig = 2'b10;
    step();
    sig_valid = 1'b0;
    tests++;
    if (drop_cnt !== 16'd3 || busy !== 1'b0 || ord_valid !== 1'b0) begin
      fails++;
      $display("FAIL illegal_drop: got drop=%0d busy=%b v=%b, want 3 0 0", drop_cnt, busy, ord_valid);
    end
  endtask

  task automatic b_order(input logic [1:0] s, input logic with_px);
    b_ord_ready = 1'b1;
    b_px_valid = with_px; b_px = 32'h0064_0000;
    b_sig_valid = 1'b1; b_sig = s;
    step();
    b_px_valid = 1'b0; b_sig_valid = 1'b0;
  endtask

  task automatic test_clamp();
    b_order(2'b01, 1'b1);
    tests++;
    if (b_ord_valid !== 1'b1 || b_ord_qty !== 8'd3 || b_ord_side !== 1'b0) begin
      fails++;
      $display("FAIL clamp_buy1: got v=%b q=%0d s=%b, want 1 3 0", b_ord_valid, b_ord_qty, b_ord_side);
    end
    step(11);
    b_order(2'b01, 1'b0);
    tests++;
    if (b_ord_valid !== 1'b1 || b_ord_qty !== 8'd1) begin
      fails++;
      $display("FAIL clamp_buy2: got v=%b q=%0d, want 1 1", b_ord_valid, b_ord_qty);
    end
    step(11);
    tests++;
    if (b_position !== 8'd4) begin
      fails++;
      $display("FAIL clamp_pos_max: got %0d, want 4", b_position);
    end
    b_order(2'b01, 1'b0);
    tests++;
    if (b_ord_valid !== 1'b0 || b_drop_cnt !== 16'd1 || b_position !== 8'd4) begin
      fails++;
      $display("FAIL clamp_limit_drop: got v=%b drop=%0d pos=%0d, want 0 1 4",
               b_ord_valid, b_drop_cnt, b_position);
    end
    b_order(2'b11, 1'b0);
    tests++;
    if (b_ord_valid !== 1'b1 || b_ord_qty !== 8'd3 || b_ord_side !== 1'b1) begin
      fails++;
      $display("FAIL clamp_sell: got v=%b q=%0d s=%b, want 1 3 1", b_ord_valid, b_ord_qty, b_ord_side);
    end
    step();
    tests++;
    if (b_position !== 8'd1) begin
      fails++;
      $display("FAIL clamp_pos_after_sell: got %0d, want 1", b_position);
    end
    step(10);
  endtask

  task automatic test_reset_mid_send();
    ord_ready = 1'b0;
    sig_valid = 1'b1; sig = 2'b01;
    step();
    sig_valid = 1'b0;
    tests++;
    if (ord_valid !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL rst_pre_send: got v=%b busy=%b, want 1 1", ord_valid, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({ord_valid, ord_side, ord_qty, ord_px, position, busy, drop_cnt} !== '0) begin
      fails++;
      $display("FAIL rst_async: got v=%b s=%b q=%0d px=%h pos=%0d busy=%b drop=%0d, want all 0",
               ord_valid, ord_side, ord_qty, ord_px, position, busy, drop_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    ord_ready = 1'b1;
    step(3);
    tests++;
    if (ord_valid !== 1'b0 || position !== 8'd0) begin
      fails++;
      $display("FAIL rst_no_handshake: got v=%b pos=%0d, want 0 0", ord_valid, position);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    px_valid = 1'b0; px = '0; sig_valid = 1'b0; sig = '0; ord_ready = 1'b0;
    b_px_valid = 1'b0; b_px = '0; b_sig_valid = 1'b0; b_sig = '0; b_ord_ready = 1'b0;
    step(2);
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    test_no_price();
    test_basic();
    test_backpressure();
    test_bypass();
    test_illegal();
    test_clamp();
    test_reset_mid_send();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
